// File: rtl/rv_pipe_pkg.sv
// Shared pipeline-control types for the 5-stage RV32I core: forwarding selects,
// hazard-sequencer state encoding and the bundled stall/flush control word.
package rv_pipe_pkg;

    localparam int REG_NUM_SIZE = 5;

    typedef logic [REG_NUM_SIZE-1:0] reg_num_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        HZ_RUN      = 1'b0,
        HZ_MEM_WAIT = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_w;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_IDLE = '0;

    // Data-memory freeze: hold everything up to M and feed WB bubbles.
    localparam pipe_ctrl_t CTRL_FREEZE = '{
        stall_f: 1'b1, stall_d: 1'b1, stall_e: 1'b1, stall_m: 1'b1,
        flush_d: 1'b0, flush_e: 1'b0, flush_w: 1'b1
    };

    // A producer matches a consumer only if it writes, is not x0, and names the same register.
    function automatic logic reg_match(input logic we, input reg_num_t rd, input reg_num_t rs);
        return we && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// EX operand forwarding comparator: picks MEM, WB or register-file value for one source.
module fwd_unit
    import rv_pipe_pkg::*;
(
    input  reg_num_t rs_e_i,
    input  reg_num_t rd_m_i,
    input  logic     we_m_i,
    input  reg_num_t rd_w_i,
    input  logic     we_w_i,
    output fwd_sel_e sel_o
);

    // MEM holds the younger result, so it is checked before WB.
    always_comb begin
        if (reg_match(we_m_i, rd_m_i, rs_e_i)) begin
            sel_o = FWD_MEM;
        end else if (reg_match(we_w_i, rd_w_i, rs_e_i)) begin
            sel_o = FWD_WB;
        end else begin
            sel_o = FWD_RF;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: EX forwarding, load-use stall, branch flush, data-memory wait freeze,
// plus a saturating stall-cycle counter and a sticky memory-timeout flag.
module pipe_hazard_ctrl
    import rv_pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rs1_e,
    input  logic [4:0]       rs2_e,
    input  logic [4:0]       rd_e,
    input  logic             de_we_e,
    input  logic             mem_reg_e,
    input  logic [4:0]       rd_m,
    input  logic             de_we_m,
    input  logic [4:0]       rd_w,
    input  logic             de_we_w,
    input  logic             brn_taken_e,
    input  logic             mem_req_m,
    input  logic             mem_ready,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_w,
    output logic             mem_wait,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    hz_state_e         state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    pipe_ctrl_t ctrl;
    fwd_sel_e   fwd_a_sel, fwd_b_sel;
    logic       load_use;
    logic       mem_miss;

    fwd_unit u_fwd_a (
        .rs_e_i (rs1_e),
        .rd_m_i (rd_m),
        .we_m_i (de_we_m),
        .rd_w_i (rd_w),
        .we_w_i (de_we_w),
        .sel_o  (fwd_a_sel)
    );

    fwd_unit u_fwd_b (
        .rs_e_i (rs2_e),
        .rd_m_i (rd_m),
        .we_m_i (de_we_m),
        .rd_w_i (rd_w),
        .we_w_i (de_we_w),
        .sel_o  (fwd_b_sel)
    );

    assign load_use = mem_reg_e &&
                      (reg_match(de_we_e, rd_e, rs1_d) || reg_match(de_we_e, rd_e, rs2_d));
    assign mem_miss = mem_req_m && !mem_ready;

    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    always_comb begin
        ctrl       = CTRL_IDLE;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;

        case (state_q)
            HZ_RUN: begin
                if (mem_miss) begin
                    ctrl       = CTRL_FREEZE;
                    state_d    = HZ_MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end else if (brn_taken_e) begin
                    // Branch outranks load-use: the dependent instruction is squashed anyway.
                    ctrl.flush_d = 1'b1;
                    ctrl.flush_e = 1'b1;
                end else if (load_use) begin
                    ctrl.stall_f = 1'b1;
                    ctrl.stall_d = 1'b1;
                    ctrl.flush_e = 1'b1;
                end
            end
            HZ_MEM_WAIT: begin
                // The release cycle still stalls; held instructions are re-evaluated in RUN.
                ctrl = CTRL_FREEZE;
                if (mem_ready) begin
                    state_d    = HZ_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q < WAIT_MAX) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = HZ_RUN;
            end
        endcase

        if ((state_d == HZ_MEM_WAIT) && (wait_cnt_d >= WAIT_MAX)) begin
            mem_err_d = 1'b1;
        end
    end

    assign stall_cnt_d = (ctrl.stall_f && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1)
                                                               : stall_cnt_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= HZ_RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Combinational outputs are forced quiet while reset is held, independent of the inputs.
    assign fwd_a     = rst ? fwd_a_sel : FWD_RF;
    assign fwd_b     = rst ? fwd_b_sel : FWD_RF;
    assign stall_f   = rst && ctrl.stall_f;
    assign stall_d   = rst && ctrl.stall_d;
    assign stall_e   = rst && ctrl.stall_e;
    assign stall_m   = rst && ctrl.stall_m;
    assign flush_d   = rst && ctrl.flush_d;
    assign flush_e   = rst && ctrl.flush_e;
    assign flush_w   = rst && ctrl.flush_w;
    assign mem_wait  = rst && (state_q == HZ_MEM_WAIT);
    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios plus random traffic,
// checked against a cycle-level behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
        logic       we_e, ld_e, we_m, we_w, brn, req, rdy;
    } stim_t;

    typedef struct packed {
        logic [1:0]       fa, fb;
        logic             sf, sd, se, sm, fd, fe, fw, mw, me;
        logic [CNT_W-1:0] sc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic             de_we_e, mem_reg_e, de_we_m, de_we_w;
    logic             brn_taken_e, mem_req_m, mem_ready;
    logic [1:0]       fwd_a, fwd_b;
    logic             stall_f, stall_d, stall_e, stall_m;
    logic             flush_d, flush_e, flush_w;
    logic             mem_wait, mem_err;
    logic [CNT_W-1:0] stall_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rs1_d       (rs1_d),
        .rs2_d       (rs2_d),
        .rs1_e       (rs1_e),
        .rs2_e       (rs2_e),
        .rd_e        (rd_e),
        .de_we_e     (de_we_e),
        .mem_reg_e   (mem_reg_e),
        .rd_m        (rd_m),
        .de_we_m     (de_we_m),
        .rd_w        (rd_w),
        .de_we_w     (de_we_w),
        .brn_taken_e (brn_taken_e),
        .mem_req_m   (mem_req_m),
        .mem_ready   (mem_ready),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .stall_e     (stall_e),
        .stall_m     (stall_m),
        .flush_d     (flush_d),
        .flush_e     (flush_e),
        .flush_w     (flush_w),
        .mem_wait    (mem_wait),
        .mem_err     (mem_err),
        .stall_cnt   (stall_cnt)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model state: plain integers describing the memory-wait episode.
    bit m_in_wait;
    bit m_err;
    int m_wait_n;
    int m_scnt;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input stim_t s);
        if (s.we_m && s.rd_m != 0 && s.rd_m == rs) return 2'd2;
        if (s.we_w && s.rd_w != 0 && s.rd_w == rs) return 2'd1;
        return 2'd0;
    endfunction

    function automatic exp_t model_out(input stim_t s);
        exp_t e;
        bit   hazard_ld;
        e = '0;
        if (!s.rst) return e;
        e.fa = ref_fwd(s.rs1_e, s);
        e.fb = ref_fwd(s.rs2_e, s);
        hazard_ld = s.ld_e && s.we_e && s.rd_e != 0 && (s.rd_e == s.rs1_d || s.rd_e == s.rs2_d);
        if (m_in_wait || (s.req && !s.rdy)) begin
            {e.sf, e.sd, e.se, e.sm, e.fw} = 5'b11111;
        end else if (s.brn) begin
            {e.fd, e.fe} = 2'b11;
        end else if (hazard_ld) begin
            {e.sf, e.sd, e.fe} = 3'b111;
        end
        e.mw = m_in_wait;
        e.me = m_err;
        e.sc = CNT_W'(m_scnt);
        return e;
    endfunction

    task automatic model_step(input stim_t s, input exp_t e);
        if (!s.rst) begin
            m_in_wait = 0;
            m_err     = 0;
            m_wait_n  = 0;
            m_scnt    = 0;
            return;
        end
        if (e.sf) m_scnt = (m_scnt == CNT_MAX) ? CNT_MAX : m_scnt + 1;
        if (m_in_wait) begin
            if (s.rdy) begin
                m_in_wait = 0;
                m_wait_n  = 0;
            end else if (m_wait_n < MEM_TIMEOUT) begin
                m_wait_n = m_wait_n + 1;
            end
        end else if (s.req && !s.rdy) begin
            m_in_wait = 1;
            m_wait_n  = 1;
        end
        if (m_in_wait && m_wait_n >= MEM_TIMEOUT) m_err = 1;
    endtask

    task automatic drive_cycle(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        rst         = s.rst;
        rs1_d       = s.rs1_d;
        rs2_d       = s.rs2_d;
        rs1_e       = s.rs1_e;
        rs2_e       = s.rs2_e;
        rd_e        = s.rd_e;
        rd_m        = s.rd_m;
        rd_w        = s.rd_w;
        de_we_e     = s.we_e;
        mem_reg_e   = s.ld_e;
        de_we_m     = s.we_m;
        de_we_w     = s.we_w;
        brn_taken_e = s.brn;
        mem_req_m   = s.req;
        mem_ready   = s.rdy;
        e = model_out(s);
        exp_q.push_back(e);
        model_step(s, e);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s     = '0;
        s.rst = 1'b1;
        return s;
    endfunction

    task automatic reset_pulse();
        stim_t s;
        s = idle();
        s.rst = 1'b0;
        drive_cycle(s);
        drive_cycle(idle());
    endtask

    // Monitor: outputs are presented every cycle; compare at the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("fwd_a",     int'(fwd_a),     int'(mon_e.fa));
            check("fwd_b",     int'(fwd_b),     int'(mon_e.fb));
            check("stall_f",   int'(stall_f),   int'(mon_e.sf));
            check("stall_d",   int'(stall_d),   int'(mon_e.sd));
            check("stall_e",   int'(stall_e),   int'(mon_e.se));
            check("stall_m",   int'(stall_m),   int'(mon_e.sm));
            check("flush_d",   int'(flush_d),   int'(mon_e.fd));
            check("flush_e",   int'(flush_e),   int'(mon_e.fe));
            check("flush_w",   int'(flush_w),   int'(mon_e.fw));
            check("mem_wait",  int'(mem_wait),  int'(mon_e.mw));
            check("mem_err",   int'(mem_err),   int'(mon_e.me));
            check("stall_cnt", int'(stall_cnt), int'(mon_e.sc));
        end
    end

    initial begin
        stim_t s;
        rst = 1'b0;
        {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
        {de_we_e, mem_reg_e, de_we_m, de_we_w, brn_taken_e, mem_req_m, mem_ready} = '0;

        reset_pulse();

        // Forwarding: MEM beats WB, WB when MEM does not write, never from x0.
        s = idle();
        s.rd_m = 5; s.we_m = 1; s.rd_w = 5; s.we_w = 1; s.rs1_e = 5; s.rs2_e = 5;
        drive_cycle(s);
        @(negedge clk) check("dir_fwd_mem", int'(fwd_a), 2);
        s.we_m = 0;
        drive_cycle(s);
        @(negedge clk) check("dir_fwd_wb", int'(fwd_a), 1);
        s.we_m = 1; s.rd_m = 0; s.rd_w = 0; s.rs1_e = 0;
        drive_cycle(s);
        @(negedge clk) check("dir_fwd_x0", int'(fwd_a), 0);

        // Load x3 in E, consumer in D reads x3 via rs2.
        s = idle();
        s.ld_e = 1; s.we_e = 1; s.rd_e = 3; s.rs2_d = 3;
        drive_cycle(s);
        @(negedge clk) check("dir_lu_stall", int'({stall_f, stall_d, flush_e}), 7);
        s = idle();
        s.rd_m = 3; s.we_m = 1; s.rs2_e = 3;
        drive_cycle(s);
        @(negedge clk) check("dir_lu_release", int'({stall_f, stall_d, flush_e, fwd_b}), 2);

        // Load-use and taken branch together: branch wins.
        s = idle();
        s.ld_e = 1; s.we_e = 1; s.rd_e = 7; s.rs1_d = 7; s.brn = 1;
        drive_cycle(s);
        @(negedge clk) check("dir_brn_wins", int'({stall_f, flush_d, flush_e}), 3);

        // Memory wait: 3 not-ready cycles then ready.
        reset_pulse();
        s = idle();
        s.req = 1;
        repeat (3) drive_cycle(s);
        s.rdy = 1;
        drive_cycle(s);
        drive_cycle(idle());
        @(negedge clk) check("dir_mem_stall_cnt", int'(stall_cnt), 4);

        // Timeout: mem_ready never comes for a while; mem_err stays set after release.
        reset_pulse();
        s = idle();
        s.req = 1;
        repeat (6) drive_cycle(s);
        s.rdy = 1;
        drive_cycle(s);
        drive_cycle(idle());
        drive_cycle(idle());
        @(negedge clk) check("dir_mem_err_sticky", int'(mem_err), 1);

        // Reset asserted in the middle of a wait.
        s = idle();
        s.req = 1;
        repeat (2) drive_cycle(s);
        s.rst = 0;
        drive_cycle(s);
        @(negedge clk) check("dir_rst_mid_wait", int'({stall_f, mem_wait, mem_err, stall_cnt}), 0);
        drive_cycle(idle());

        // Saturation of the stall counter under continuous load-use stalls.
        s = idle();
        s.ld_e = 1; s.we_e = 1; s.rd_e = 1; s.rs1_d = 1;
        repeat (20) drive_cycle(s);
        @(negedge clk) check("dir_cnt_saturate", int'(stall_cnt), CNT_MAX);

        // Random traffic over a small register window to provoke hazards.
        for (int i = 0; i < 1500; i++) begin
            s.rst   = ($urandom_range(0, 199) != 0);
            s.rs1_d = 5'($urandom_range(0, 3));
            s.rs2_d = 5'($urandom_range(0, 3));
            s.rs1_e = 5'($urandom_range(0, 3));
            s.rs2_e = 5'($urandom_range(0, 3));
            s.rd_e  = 5'($urandom_range(0, 3));
            s.rd_m  = 5'($urandom_range(0, 3));
            s.rd_w  = 5'($urandom_range(0, 3));
            s.we_e  = 1'($urandom_range(0, 1));
            s.ld_e  = ($urandom_range(0, 9) < 4);
            s.we_m  = 1'($urandom_range(0, 1));
            s.we_w  = 1'($urandom_range(0, 1));
            s.brn   = ($urandom_range(0, 9) < 2);
            s.req   = ($urandom_range(0, 9) < 3);
            s.rdy   = 1'($urandom_range(0, 1));
            drive_cycle(s);
        end

        drive_cycle(idle());
        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
